// File: rtl/td4_program_sequencer.sv
// td4_program_sequencer
// Program store and execution controller for a 4-bit TD4-style core.
// Holds 16 x 8-bit program words, presents {opcode, immediate} for the
// core's PC, and issues per-instruction step pulses under HALT / RUN /
// STEP / CLEAR commands with a run-rate divider and a PC breakpoint.
//
// Handshake: a program write happens on a cycle where load_valid and
// load_ready are both high; load_ready is high only while halted (IDLE),
// and load_valid may be held or dropped freely without side effects.
// Commands have no ready: cmd_valid is sampled every cycle and a command
// that the current state does not accept is dropped.
module td4_program_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [3:0] load_addr,
  input  logic [7:0] load_data,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [7:0] div,
  input  logic       bp_en,
  input  logic [3:0] bp_addr,
  input  logic [3:0] pc_in,
  output logic [3:0] opcode,
  output logic [3:0] immediate,
  output logic       cpu_step,
  output logic       cpu_rst,
  output logic       halted,
  output logic       bp_hit,
  output logic [7:0] step_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam logic [1:0] CMD_HALT  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  logic [7:0] mem_q [16];
  state_t     state_q;
  logic [7:0] div_cnt_q;
  logic       clr_cnt_q;
  logic       bp_hit_q;
  logic [7:0] step_count_q;

  logic       div_hit;
  logic       bp_match;
  logic       halt_cmd;
  logic       clear_cmd;
  logic       load_fire;
  logic [7:0] cur_word;

  // Decode of the current state plus live div / pc / command inputs.
  always_comb begin
    div_hit   = (div_cnt_q == div);
    bp_match  = bp_en && (pc_in == bp_addr);
    halt_cmd  = cmd_valid && (cmd == CMD_HALT);
    clear_cmd = cmd_valid && (cmd == CMD_CLEAR);
    load_fire = load_valid && (state_q == S_IDLE);
    cur_word  = mem_q[pc_in];
    // A RUN step fires only on exact divider equality, never before a
    // breakpointed instruction, and never in the cycle HALT is sampled.
    cpu_step  = (state_q == S_STEP) ||
                ((state_q == S_RUN) && div_hit && !bp_match && !halt_cmd);
  end

  assign opcode     = cur_word[7:4];
  assign immediate  = cur_word[3:0];
  assign load_ready = (state_q == S_IDLE);
  assign halted     = (state_q == S_IDLE);
  assign cpu_rst    = (state_q == S_CLEAR);
  assign bp_hit     = bp_hit_q;
  assign step_count = step_count_q;
  assign dbg_state  = state_q;

  // Program memory: cleared by reset, written only through the load handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else if (load_fire) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Control FSM with divider, clear timer, breakpoint flag and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= 8'd0;
      clr_cnt_q    <= 1'b0;
      bp_hit_q     <= 1'b0;
      step_count_q <= 8'd0;
    end else begin
      // Saturating count; a CLEAR entry below takes priority over it.
      if (cpu_step && (step_count_q != 8'hFF)) step_count_q <= step_count_q + 8'd1;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd)
              CMD_RUN: begin
                state_q   <= S_RUN;
                div_cnt_q <= 8'd0;
                bp_hit_q  <= 1'b0;
              end
              CMD_STEP: begin
                state_q  <= S_STEP;
                bp_hit_q <= 1'b0;
              end
              CMD_CLEAR: begin
                state_q      <= S_CLEAR;
                clr_cnt_q    <= 1'b0;
                bp_hit_q     <= 1'b0;
                step_count_q <= 8'd0;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (clear_cmd) begin
            state_q      <= S_CLEAR;
            clr_cnt_q    <= 1'b0;
            bp_hit_q     <= 1'b0;
            step_count_q <= 8'd0;
          end else if (halt_cmd) begin
            state_q <= S_IDLE;
          end else if (div_hit) begin
            div_cnt_q <= 8'd0;
            if (bp_match) begin
              state_q  <= S_IDLE;
              bp_hit_q <= 1'b1;
            end
          end else begin
            // Free-running wrap: lowering div below the count never
            // produces an early step.
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        S_STEP: begin
          state_q <= S_IDLE;
        end
        S_CLEAR: begin
          if (clr_cnt_q) state_q <= S_IDLE;
          else           clr_cnt_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_program_sequencer.sv
// Testbench for td4_program_sequencer with a small TD4 core model
// (MOV A,imm = 0xC, ADD A,imm = 0x0) closing the PC loop.
module tb_td4_program_sequencer;

  localparam logic [1:0] C_HALT  = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       load_valid, load_ready;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic [7:0] div;
  logic       bp_en;
  logic [3:0] bp_addr;
  logic [3:0] pc_in;
  logic [3:0] opcode, immediate;
  logic       cpu_step, cpu_rst, halted, bp_hit;
  logic [7:0] step_count;
  logic [1:0] dbg_state;

  td4_program_sequencer dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data),
    .cmd_valid(cmd_valid), .cmd(cmd), .div(div),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc_in(pc_in),
    .opcode(opcode), .immediate(immediate),
    .cpu_step(cpu_step), .cpu_rst(cpu_rst), .halted(halted),
    .bp_hit(bp_hit), .step_count(step_count), .dbg_state(dbg_state)
  );

  // ---------------- core model ----------------
  logic [3:0] core_pc, core_a;
  logic       pc_force_en;
  logic [3:0] pc_force;
  assign pc_in = pc_force_en ? pc_force : core_pc;

  always @(posedge clk) begin
    if (rst || cpu_rst) begin
      core_pc <= 4'd0;
      core_a  <= 4'd0;
    end else if (cpu_step) begin
      core_pc <= core_pc + 4'd1;
      case (opcode)
        4'hC:    core_a <= immediate;
        4'h0:    core_a <= core_a + immediate;
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present a command for one cycle; returns at the start of the first
  // cycle spent in the resulting state (inputs not yet settled).
  task automatic issue(input logic [1:0] c);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Read all 16 words through pc_in and compare against queued words.
  task automatic readback(input string name);
    logic [7:0] e;
    pc_force_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pc_force = 4'(i);
      #1;
      if (exp_q.size() == 0) begin
        chk({name, "_underflow"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk(name, {opcode, immediate}, e);
      end
    end
    pc_force_en = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int pulses;
  int first_pulse;

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    cmd_valid = 1'b0; cmd = C_HALT; div = 8'd0; bp_en = 1'b0; bp_addr = '0;
    pc_force_en = 1'b0; pc_force = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_halted", halted, 1);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_step_count", step_count, 0);
    chk("rst_cpu_step", cpu_step, 0);
    chk("rst_cpu_rst", cpu_rst, 0);
    chk("rst_bp_hit", bp_hit, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
    readback("rst_mem");

    // Program table: MOV A,5 ; ADD A,3 ; then arbitrary words.
    tbl[0] = '{addr: 4'd0, data: 8'hC5};
    tbl[1] = '{addr: 4'd1, data: 8'h03};
    for (int i = 2; i < 16; i++) begin
      tbl[i].addr = 4'(i);
      tbl[i].data = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = tbl[i].addr;
      load_data  = tbl[i].data;
      #1;
      chk("load_ready_idle", load_ready, 1);
    end
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(tbl[i].data);
    readback("load_mem");

    // Two single steps.
    for (int k = 0; k < 2; k++) begin
      issue(C_STEP);
      #1;
      chk("step_pulse", cpu_step, 1);
      chk("step_not_halted", halted, 0);
      @(negedge clk);
      #1;
      chk("step_one_cycle", cpu_step, 0);
      chk("step_back_idle", halted, 1);
    end
    chk("step_core_a", core_a, 8);
    chk("step_count2", step_count, 2);
    chk("step_core_pc", core_pc, 2);

    // RUN div=3: pulses in RUN cycles 4, 8, 12; HALT sampled in cycle 14.
    div = 8'd3;
    exp_q.delete();
    exp_q.push_back(8'd4); exp_q.push_back(8'd8); exp_q.push_back(8'd12);
    issue(C_RUN);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      load_valid = (c == 2);
      load_addr  = 4'd15;
      load_data  = ~tbl[15].data;
      cmd_valid  = (c == 14);
      cmd        = C_HALT;
      #1;
      if (c <= 14) chk("run_load_ready", load_ready, 0);
      if (c >= 15) chk("run_halted_after", halted, 1);
      if (cpu_step) begin
        if (exp_q.size() == 0) chk("run_extra_pulse", c, 0);
        else chk("run_pulse_cycle", c, exp_q.pop_front());
      end
    end
    load_valid = 1'b0;
    cmd_valid  = 1'b0;
    chk("run_missing_pulses", exp_q.size(), 0);
    chk("run_step_count", step_count, 5);

    // CLEAR from RUN: 2 cycles of cpu_rst, counters cleared, memory kept.
    div = 8'd7;
    issue(C_RUN);
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = C_CLEAR;
    #1;
    chk("clr_sample_no_step", cpu_step, 0);
    @(negedge clk);
    cmd = C_RUN;   // ignored while clearing
    #1;
    chk("clr1_cpu_rst", cpu_rst, 1);
    chk("clr1_cpu_step", cpu_step, 0);
    chk("clr1_step_count", step_count, 0);
    chk("clr1_halted", halted, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("clr2_cpu_rst", cpu_rst, 1);
    chk("clr2_cpu_step", cpu_step, 0);
    @(negedge clk);
    #1;
    chk("clr_end_cpu_rst", cpu_rst, 0);
    chk("clr_end_halted", halted, 1);
    chk("clr_core_pc", core_pc, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(tbl[i].data);
    readback("clr_mem");

    // Breakpoint at 5 with div=0 from PC 0.
    bp_en = 1'b1; bp_addr = 4'd5; div = 8'd0;
    pulses = 0;
    issue(C_RUN);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      if (halted) break;
      if (cpu_step) pulses++;
    end
    chk("bp_pulses", pulses, 5);
    chk("bp_halted", halted, 1);
    chk("bp_hit_set", bp_hit, 1);
    chk("bp_pc", pc_in, 5);
    chk("bp_step_count", step_count, 5);
    issue(C_STEP);
    #1;
    chk("bp_step_pulse", cpu_step, 1);
    chk("bp_hit_cleared", bp_hit, 0);
    @(negedge clk);
    #1;
    chk("bp_step_idle", halted, 1);
    chk("bp_step_pc", core_pc, 6);
    chk("bp_step_count6", step_count, 6);

    // HALT in the first RUN cycle with div=0 suppresses that step.
    bp_en = 1'b0;
    issue(C_RUN);
    cmd_valid = 1'b1;
    cmd       = C_HALT;
    #1;
    chk("halt_no_step", cpu_step, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("halt_idle", halted, 1);
    chk("halt_step_count", step_count, 6);

    // div lowered below div_cnt: wrap through 255, first step in cycle 258.
    div = 8'd5;
    first_pulse = 0;
    issue(C_RUN);
    for (int c = 1; c <= 270; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 4) div = 8'd1;
      #1;
      if (cpu_step) begin
        first_pulse = c;
        break;
      end
    end
    chk("wrap_first_pulse", first_pulse, 258);
    issue(C_HALT);
    #1;
    chk("wrap_step_count", step_count, 7);

    // Saturation of step_count.
    div = 8'd0;
    issue(C_RUN);
    repeat (300) @(negedge clk);
    issue(C_HALT);
    #1;
    chk("sat_step_count", step_count, 255);

    // Reset mid-RUN with div_cnt != 0.
    div = 8'd3;
    issue(C_RUN);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_halted", halted, 1);
    chk("mid_rst_cpu_step", cpu_step, 0);
    chk("mid_rst_step_count", step_count, 0);
    chk("mid_rst_load_ready", load_ready, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
    readback("mid_rst_mem");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
